// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  typedef struct packed {
    logic              valid;
    port_t             port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } stage_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: pure grant logic for the fetch and data ports.
// Build option MEM_ARB_RR_EN selects round-robin on conflicts; the default
// build gives the data port fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  if_req,
  input  logic  d_req,
  input  port_t rr_last,
  output logic  if_gnt,
  output logic  d_gnt,
  output port_t winner
);

`ifdef MEM_ARB_RR_EN
  // Round-robin: on a conflict the port not granted last conflict wins.
  always_comb begin
    d_gnt  = d_req & (~if_req | (rr_last == PORT_IF));
    if_gnt = if_req & (~d_req | (rr_last == PORT_D));
    winner = d_gnt ? PORT_D : PORT_IF;
  end
`else
  // Pointer has no effect with fixed priority.
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  // Fixed priority: the data port wins every conflict.
  always_comb begin
    d_gnt  = d_req;
    if_gnt = if_req & ~d_req;
    winner = d_gnt ? PORT_D : PORT_IF;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction fetch and data load/store requests onto
// the single port of a 256x8 memory, one access per cycle, with read data
// returned to the requesting port two edges after acceptance.
// Build option MEM_ARB_RR_EN enables round-robin conflict arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  stage_t            stg;
  port_t             rr_last;
  port_t             winner;
  logic              if_req_en;
  logic              d_req_en;
  logic              accept;
  logic              conflict;
  logic [DATA_W-1:0] ret_data;

  // Requests are masked while in reset so no grant is issued.
  assign if_req_en = if_req & rst_n;
  assign d_req_en  = d_req & rst_n;
  assign conflict  = if_req_en & d_req_en;
  assign accept    = if_gnt | d_gnt;

  mem_arb_pick u_pick (
    .if_req  (if_req_en),
    .d_req   (d_req_en),
    .rr_last (rr_last),
    .if_gnt  (if_gnt),
    .d_gnt   (d_gnt),
    .winner  (winner)
  );

  // Stage register: capture the granted request; fields hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg.valid <= accept;
      if (accept) begin
        stg.port <= winner;
        stg.we   <= (winner == PORT_D) && d_we;
        stg.addr <= (winner == PORT_D) ? d_addr : if_addr;
        if (winner == PORT_D) begin
          stg.wdata <= d_wdata;
        end
      end
    end
  end

  // Memory is driven straight from the stage; reset kills a pending store.
  assign mem_we   = stg.valid & stg.we & rst_n;
  assign mem_addr = stg.addr;
  assign mem_in   = stg.wdata;

  // Return register: latch read data and pulse the owning port's rvalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ret_data  <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      if_rvalid <= stg.valid & ~stg.we & (stg.port == PORT_IF);
      d_rvalid  <= stg.valid & ~stg.we & (stg.port == PORT_D);
      if (stg.valid && !stg.we) begin
        ret_data <= mem_out;
      end
    end
  end

  assign if_rdata = ret_data;
  assign d_rdata  = ret_data;

  // Conflict pointer: remembers which port won the most recent conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= PORT_IF;
    end else if (conflict) begin
      rr_last <= winner;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model and a behavioural 256x8 memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_gnt;
  logic       if_rvalid;
  logic [7:0] if_rdata;
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_gnt;
  logic       d_rvalid;
  logic [7:0] d_rdata;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_in;
  logic [7:0] mem_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_in;
  assign mem_out = mem[mem_addr];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
  );

  // Reference model: one in-flight access, one pending return.
  bit       m_inf_v, m_inf_d, m_inf_we;
  bit [7:0] m_inf_addr, m_inf_wdata;
  bit       m_ret_v, m_ret_d;
  bit [7:0] m_ret_data, m_last_addr;
  bit       m_rr_d_last;
  bit       m_gi, m_gd;

  function automatic void exp_gnt(output bit gi, output bit gd);
    gi = 1'b0;
    gd = 1'b0;
    if (rst_n) begin
      if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        gd = ~m_rr_d_last;
        gi = m_rr_d_last;
`else
        gd = 1'b1;
`endif
      end else begin
        gi = if_req;
        gd = d_req;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit gi, gd, we_exp;
    exp_gnt(gi, gd);
    we_exp = m_inf_v && m_inf_we && rst_n;
    chk("if_gnt", if_gnt, gi);
    chk("d_gnt", d_gnt, gd);
    chk("if_rvalid", if_rvalid, m_ret_v && !m_ret_d);
    chk("d_rvalid", d_rvalid, m_ret_v && m_ret_d);
    chk("if_rdata", if_rdata, m_ret_data);
    chk("d_rdata", d_rdata, m_ret_data);
    chk("mem_we", mem_we, we_exp);
    chk("mem_addr", mem_addr, m_last_addr);
    if (we_exp) chk("mem_in", mem_in, m_inf_wdata);
  endtask

  task automatic model_edge();
    bit gi, gd;
    if (!rst_n) begin
      m_inf_v = 0; m_ret_v = 0; m_ret_data = 0; m_last_addr = 0;
      m_rr_d_last = 0; m_gi = 0; m_gd = 0;
    end else begin
      exp_gnt(gi, gd);
      m_ret_v = m_inf_v && !m_inf_we;
      m_ret_d = m_inf_d;
      if (m_ret_v) m_ret_data = ref_mem[m_inf_addr];
      if (m_inf_v && m_inf_we) ref_mem[m_inf_addr] = m_inf_wdata;
      if (if_req && d_req) m_rr_d_last = gd;
      m_gi = gi;
      m_gd = gd;
      m_inf_v = gi || gd;
      if (gd) begin
        m_inf_d = 1; m_inf_we = d_we; m_inf_addr = d_addr; m_inf_wdata = d_wdata;
      end else if (gi) begin
        m_inf_d = 0; m_inf_we = 0; m_inf_addr = if_addr;
      end
      if (m_inf_v) m_last_addr = m_inf_addr;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    bit exp_d;
    logic [7:0] saved40;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;
    for (int i = 0; i < 8; i++) mem[i] = 8'h50 + 8'(i);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    // Reset state
    @(posedge clk); model_edge(); #1;
    at_neg();
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_rdata", if_rdata, 0);
    at_pos();
    rst_n = 1;
    at_neg(); at_pos();

    // Single fetch from 0x10
    if_req = 1; if_addr = 8'h10;
    at_neg(); chk("fetch_gnt", if_gnt, 1); chk("fetch_dgnt", d_gnt, 0);
    at_pos(); if_req = 0;
    at_neg(); chk("fetch_early", if_rvalid, 0);
    at_pos();
    at_neg(); chk("fetch_rvalid", if_rvalid, 1); chk("fetch_rdata", if_rdata, 8'hA5);
    chk("fetch_no_drv", d_rvalid, 0);
    at_pos();
    at_neg(); chk("fetch_pulse", if_rvalid, 0);
    at_pos();

    // Store 0x3C to 0x20 then load 0x20 back to back
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C;
    at_neg(); at_pos();
    d_we = 0;
    at_neg(); chk("st_we", mem_we, 1); chk("st_addr", mem_addr, 8'h20); chk("st_in", mem_in, 8'h3C);
    at_pos(); d_req = 0;
    at_neg(); chk("ld_we", mem_we, 0); chk("ld_early", d_rvalid, 0);
    at_pos();
    at_neg(); chk("ld_rvalid", d_rvalid, 1); chk("ld_rdata", d_rdata, 8'h3C);
    at_pos();

    // Conflict for 4 cycles
    if_req = 1; if_addr = 8'h01; d_req = 1; d_we = 0; d_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      at_neg();
`ifdef MEM_ARB_RR_EN
      exp_d = (i % 2) == 0;
`else
      exp_d = 1;
`endif
      chk("conf_dgnt", d_gnt, exp_d);
      chk("conf_ifgnt", if_gnt, !exp_d);
      at_pos();
    end
    if_req = 0; d_req = 0;
    at_neg(); at_pos();
    at_neg(); at_pos();

    // Streaming fetch 0x00-0x07
    for (int i = 0; i < 10; i++) begin
      if_req = (i < 8); if_addr = 8'(i);
      at_neg();
      if (i >= 2) begin
        chk("stream_rvalid", if_rvalid, 1);
        chk("stream_rdata", if_rdata, 8'h50 + 8'(i - 2));
      end
      at_pos();
    end
    if_req = 0;
    at_neg(); chk("stream_end", if_rvalid, 0); at_pos();

    // Reset during a store's stage cycle
    saved40 = mem[8'h40];
    d_req = 1; d_we = 1; d_addr = 8'h40; d_wdata = 8'hEE;
    at_neg(); at_pos();
    d_req = 0; rst_n = 0;
    at_neg(); chk("rmid_we", mem_we, 0);
    at_pos();
    at_neg();
    chk("rmid_rvalid", d_rvalid, 0); chk("rmid_addr", mem_addr, 0);
    chk("rmid_in", mem_in, 0); chk("rmid_rdata", d_rdata, 0);
    rst_n = 1;
    at_pos();
    at_neg(); chk("rmid_mem40", mem[8'h40], saved40); chk("rmid_no_rv", d_rvalid, 0);
    at_pos();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (!if_req || m_gi) begin
        if_req = ($urandom % 3) != 0; if_addr = 8'($urandom % 16);
      end
      if (!d_req || m_gd) begin
        d_req = ($urandom % 3) != 0; d_we = 1'($urandom % 2);
        d_addr = 8'($urandom % 16); d_wdata = 8'($urandom);
      end
      rst_n = ($urandom % 50) != 0;
      at_neg(); at_pos();
    end
    rst_n = 1; if_req = 0; d_req = 0;
    at_neg(); at_pos();
    at_neg(); at_pos();
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port front end for the single-port 256×8 data/program memory. It sits directly upstream of the memory and merges instruction-fetch and data load/store requests onto the memory's single `we`/`in`/`addr`/`out` port, one access per cycle. Read data returns to the originating port with a fixed two-edge latency. This lets the CPU core treat fetch and data as independent request streams.

## Interface
- `ADDR_W`, 8, memory address width.
- `DATA_W`, 8, memory data width.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch request; held with `if_addr` stable until granted.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  combinational; a fetch transfer occurs at an edge where `if_req && if_gnt`.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` is valid.
- `if_rdata`  out  DATA_W  fetched byte.
- `d_req`  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  combinational grant, same rule as `if_gnt`.
- `d_rvalid`  out  1  one-cycle pulse, loads only.
- `d_rdata`  out  DATA_W  loaded byte.
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_in`  out  DATA_W  to memory `in`.
- `mem_out`  in  DATA_W  from memory `out`; combinational read of `mem_addr`.

## Operation
- One stage register holds `stg_valid`, `stg_port` (IF/D), `stg_we`, `stg_addr` and `stg_wdata`.
- The stage is always free because the memory completes in one cycle. A new request is accepted every cycle and there is no backpressure other than arbitration.
- Arbitration when only one request is active: that request is granted.
- Arbitration when both requests are active: the data port wins (fixed priority). See Configuration for round-robin.
- At most one `gnt` is high in any cycle. `gnt` depends only on `req` and arbiter state; there is no path from `gnt` back to `req`.
- Memory drive: `mem_addr = stg_addr`, `mem_in = stg_wdata`, `mem_we = stg_valid & stg_we & rst_n`.
- With the stage empty, `mem_we` is 0 and `mem_addr`/`mem_in` hold their last values.
- Read return: at the edge ending a stage cycle holding a load or fetch, `mem_out` is captured into a shared return register. The matching `*_rvalid` pulses for exactly one cycle.
- `if_rdata` and `d_rdata` both show the return register. They are meaningful only while their own `rvalid` is high.
- Stores produce no `rvalid`. A store is complete at the edge ending its stage cycle.
- Back-to-back store then load to the same address: the load returns the stored value. No forwarding is needed, because the store commits at the edge before the load's stage cycle.

## Timing
- Accept at edge E0 (`req && gnt`). The memory is accessed during the cycle E0–E1. `rvalid`/`rdata` are high during the cycle E1–E2. Load-to-use latency is 2 edges.
- Peak throughput is 1 access per cycle, sustainable on either port or both combined.
- Reset values: `stg_valid = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_in = 0`, `if_rvalid = d_rvalid = 0`, `if_rdata = d_rdata = 0`, RR pointer = "IF last".
- While `rst_n` is low, `if_gnt = d_gnt = 0`.
- Reset mid-operation: an in-flight stage is discarded. No `rvalid` is issued for it, and a pending store is not written (`mem_we` is gated by `rst_n`).
- First cycle after reset release: requests are arbitrated normally.

## Configuration
- `MEM_ARB_RR_EN` undefined: fixed priority, data port wins every conflict. Fetch can starve under continuous data requests.
- `MEM_ARB_RR_EN` defined: round-robin. A one-bit pointer records the last port granted during a conflict, and the other port wins the next conflict. The pointer updates only on conflict cycles. Its reset value is "IF last", so the first conflict goes to the data port.

## Structure
- Shared package `mem_arb_pkg`:
  - `ADDR_W` and `DATA_W` constants.
  - Port-id enum `PORT_IF = 1'b0`, `PORT_D = 1'b1`.
  - Stage record typedef (valid, port, we, addr, wdata).
- One sub-module, `mem_arb_pick`: pure grant logic. Inputs are the two requests and the RR pointer; outputs are the two grants and the winner id. It contains the `MEM_ARB_RR_EN` variant.
- The stage register, return register and pointer live in `mem_arbiter`.

## Test plan
- Single fetch: preload `mem[0x10] = 0xA5`; `if_req = 1`, `if_addr = 0x10` for one cycle -> `if_gnt` in the same cycle; `if_rvalid = 1`, `if_rdata = 0xA5` exactly 2 edges later; `d_rvalid` stays 0.
- Store then load back-to-back: store `0x3C` to `0x20` at E0, load `0x20` at E1 -> `mem_we` high only in cycle E0–E1; `d_rvalid`, `d_rdata = 0x3C` in cycle E2–E3.
- Conflict, fixed priority: both ports request continuously for 4 cycles -> `d_gnt` every cycle, `if_gnt` never; with `MEM_ARB_RR_EN`, grants go D, IF, D, IF.
- Streaming: fetch addresses `0x00`–`0x07` on consecutive cycles -> 8 consecutive `if_rvalid` pulses with the correct data, no bubbles.
- Reset mid-op: accept a store to `0x40` and drive `rst_n = 0` in its stage cycle -> `mem_we = 0`; all outputs at their reset values after the edge; no `rvalid`; `mem[0x40]` unchanged by the arbiter.
